// File: rtl/hm_deser_pkg.sv
// hm_deser_pkg: shared defaults and helpers for the hm_lane_deser staging stage.
package hm_deser_pkg;

    localparam int DEFAULT_LANES = 4;
    localparam int DEFAULT_DEPTH = 4;

    // Width of a counter that runs 0..frame-1 (never narrower than one bit).
    function automatic int frame_cnt_w(input int frame);
        return (frame <= 2) ? 1 : $clog2(frame);
    endfunction

    typedef logic [DEFAULT_LANES-1:0] lane_word_t;

endpackage

// File: rtl/hm_deser_fifo.sv
// hm_deser_fifo: synchronous DEPTH x LANES word FIFO with a registered head word.
// The head register is loaded on the edge a word becomes the oldest entry, so a
// word pushed into an empty FIFO is visible one edge later.
module hm_deser_fifo
    import hm_deser_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [LANES-1:0]         wdata,
    input  logic                     pop,
    output logic [LANES-1:0]         head,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [LANES-1:0] mem [DEPTH];

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    rd_nxt;
    logic [LW-1:0]    level_q, level_d;
    logic [LANES-1:0] head_q, head_d;
    logic             push_fire;
    logic             pop_fire;

    // Next-state for pointers, occupancy and the head word.
    always_comb begin
        pop_fire  = pop && (level_q != '0);
        push_fire = push && ((level_q != FULL_LVL) || pop_fire);
        rd_nxt    = PW'(rd_ptr_q + 1'b1);
        wr_ptr_d  = push_fire ? PW'(wr_ptr_q + 1'b1) : wr_ptr_q;
        rd_ptr_d  = pop_fire ? rd_nxt : rd_ptr_q;
        level_d   = level_q;
        case ({push_fire, pop_fire})
            2'b10:   level_d = LW'(level_q + 1'b1);
            2'b01:   level_d = LW'(level_q - 1'b1);
            default: level_d = level_q;
        endcase
        head_d = head_q;
        // Incoming word becomes head when the FIFO is (or is about to be) empty.
        if (push_fire && ((level_q == '0) || (pop_fire && (level_q == LW'(1))))) begin
            head_d = wdata;
        end else if (pop_fire && (level_q > LW'(1))) begin
            head_d = mem[rd_nxt];
        end
    end

    // Storage array, no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Control state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
        end
    end

    assign head  = head_q;
    assign level = level_q;

endmodule

// File: rtl/hm_lane_deser.sv
// hm_lane_deser: serial-to-parallel staging in front of the HM_100x400_4x4 macro.
// Bits arrive LSB (lane 0) first; completed words are queued in hm_deser_fifo.
// Define HM_DESER_PARITY_EN to append one even-parity bit to every frame and
// raise the sticky par_err flag on a bad parity bit.
module hm_lane_deser
    import hm_deser_pkg::*;
#(
    parameter int LANES = DEFAULT_LANES,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic                   in_data,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [LANES-1:0]       out_data,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   par_err
);

`ifdef HM_DESER_PARITY_EN
    localparam int FRAME = LANES + 1;
`else
    localparam int FRAME = LANES;
`endif
    localparam int CW = frame_cnt_w(FRAME);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LANES-1:0] sr_q, sr_d;
    logic             rst_q, rst_d;
    logic             accept;
    logic             last_bit;
    logic             push;
    logic [LANES-1:0] word;
    logic [LW-1:0]    fifo_level;

    // Stall on a full FIFO and for one cycle after reset.
    assign in_ready  = !rst_q && (fifo_level < FULL_LVL);
    assign accept    = in_valid && in_ready;
    assign last_bit  = (cnt_q == CW'(FRAME - 1));
    assign out_valid = (fifo_level != '0);
    assign level     = fifo_level;

`ifdef HM_DESER_PARITY_EN
    logic perr_q, perr_d;
`endif

    // Frame assembly: shift data bits toward lane 0, push on the final frame bit.
    always_comb begin
        rst_d = rst;
        cnt_d = cnt_q;
        sr_d  = sr_q;
        push  = 1'b0;
        word  = sr_q;
`ifdef HM_DESER_PARITY_EN
        perr_d = perr_q;
`endif
        if (accept) begin
            cnt_d = last_bit ? '0 : CW'(cnt_q + 1'b1);
`ifdef HM_DESER_PARITY_EN
            if (last_bit) begin
                push = 1'b1;
                word = sr_q;
                if ((^sr_q) ^ in_data) begin
                    perr_d = 1'b1;
                end
            end else begin
                sr_d            = sr_q >> 1;
                sr_d[LANES-1]   = in_data;
            end
`else
            sr_d          = sr_q >> 1;
            sr_d[LANES-1] = in_data;
            if (last_bit) begin
                push = 1'b1;
                word = sr_d;
            end
`endif
        end
    end

    // Assembly state registers.
    always_ff @(posedge clk) begin
        rst_q <= rst_d;
        if (rst) begin
            cnt_q <= '0;
            sr_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

`ifdef HM_DESER_PARITY_EN
    // Sticky parity error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end
    assign par_err = perr_q;
`else
    assign par_err = 1'b0;
`endif

    hm_deser_fifo #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (word),
        .pop   (out_ready),
        .head  (out_data),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_hm_lane_deser.sv
// tb_hm_lane_deser: scenario tasks plus a negedge scoreboard monitor for hm_lane_deser.
module tb_hm_lane_deser;
    import hm_deser_pkg::*;

    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef HM_DESER_PARITY_EN
    localparam int FRAME = LANES + 1;
`else
    localparam int FRAME = LANES;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_data;
    logic             in_ready;
    logic             out_valid;
    logic [LANES-1:0] out_data;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic             par_err;

    int checks = 0;
    int errors = 0;

    // Bench model state
    lane_word_t    sb_q[$];
    logic [LW-1:0] lvl_m   = '0;
    int            fcnt    = 0;
    lane_word_t    wacc    = '0;
    logic          pacc    = 1'b0;
    logic          par_m   = 1'b0;
    logic          rst_prev = 1'b1;

    hm_lane_deser #(.LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .level     (level),
        .par_err   (par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor: checks handshake/level each cycle, pops on consumer take.
    always @(negedge clk) begin
        logic       rdy_exp;
        logic       do_pop;
        logic       do_push;
        lane_word_t exp_w;
        if (rst) begin
            sb_q.delete();
            lvl_m    = '0;
            fcnt     = 0;
            wacc     = '0;
            pacc     = 1'b0;
            par_m    = 1'b0;
            rst_prev = 1'b1;
        end else begin
            rdy_exp = !rst_prev && (lvl_m < LW'(DEPTH));
            checks++;
            if (in_ready !== rdy_exp) begin
                errors++;
                $display("FAIL mon_in_ready: got %b want %b at %0t", in_ready, rdy_exp, $time);
            end
            checks++;
            if (level !== lvl_m) begin
                errors++;
                $display("FAIL mon_level: got %0d want %0d at %0t", level, lvl_m, $time);
            end
            checks++;
            if (out_valid !== (lvl_m != '0)) begin
                errors++;
                $display("FAIL mon_out_valid: got %b want %b at %0t", out_valid, (lvl_m != '0), $time);
            end
            checks++;
            if (par_err !== par_m) begin
                errors++;
                $display("FAIL mon_par_err: got %b want %b at %0t", par_err, par_m, $time);
            end
            do_pop = (lvl_m != '0) && out_ready;
            if (do_pop) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow: got pop want queued word at %0t", $time);
                end else begin
                    exp_w = sb_q.pop_front();
                    if (out_data !== exp_w) begin
                        errors++;
                        $display("FAIL sb_word: got %b want %b at %0t", out_data, exp_w, $time);
                    end else begin
                        $display("pop word %b level %0d at %0t", out_data, level, $time);
                    end
                end
            end
            do_push = 1'b0;
            if (in_valid && rdy_exp) begin
                pacc = pacc ^ in_data;
                if (fcnt < LANES) wacc[fcnt] = in_data;
                fcnt++;
                if (fcnt == FRAME) begin
                    do_push = 1'b1;
                    sb_q.push_back(wacc);
`ifdef HM_DESER_PARITY_EN
                    if (pacc) par_m = 1'b1;
`endif
                    fcnt = 0;
                    wacc = '0;
                    pacc = 1'b0;
                end
            end
            if (do_push && !do_pop) lvl_m = lvl_m + 1'b1;
            else if (!do_push && do_pop) lvl_m = lvl_m - 1'b1;
            rst_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input lane_word_t w);
        for (int i = 0; i < LANES; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            tick();
        end
`ifdef HM_DESER_PARITY_EN
        in_valid = 1'b1;
        in_data  = ^w;
        tick();
`endif
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL drain_timeout: got valid %b level %0d want 0 0", out_valid, level);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; out_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || level !== '0 || in_ready !== 1'b0 || out_data !== '0 || par_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got v%b l%0d r%b d%b p%b want 0 0 0 0000 0",
                     out_valid, level, in_ready, out_data, par_err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", in_ready);
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        send_frame(4'b1101);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1101 || level !== LW'(1)) begin
            errors++;
            $display("FAIL basic_word: got v%b d%b l%0d want 1 1101 1", out_valid, out_data, level);
        end
        drain();
    endtask

    task automatic test_full_stall();
        out_ready = 1'b0;
        send_frame(4'b0001);
        send_frame(4'b0110);
        send_frame(4'b1111);
        send_frame(4'b0100);
        checks++;
        if (level !== LW'(DEPTH) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level: got l%0d r%b want %0d 0", level, in_ready, DEPTH);
        end
        in_valid = 1'b1;
        in_data  = 1'b1;
        repeat (3) tick();
        checks++;
        if (level !== LW'(DEPTH) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: got l%0d r%b want %0d 0", level, in_ready, DEPTH);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_data   = 1'b0;
        checks++;
        if (level !== LW'(DEPTH - 1) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_release: got l%0d r%b want %0d 1", level, in_ready, DEPTH - 1);
        end
        send_frame(4'b1010);
        drain();
    endtask

    task automatic test_stream();
        lane_word_t w;
        logic       b;
        out_ready = 1'b1;
        for (int f = 0; f < 8; f++) begin
            w = lane_word_t'($urandom);
            for (int i = 0; i < FRAME; i++) begin
                b = (i < LANES) ? w[i] : ^w;
                in_valid = 1'b1;
                in_data  = b;
                tick();
                checks++;
                if (level > LW'(1) || in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_stall: got l%0d r%b want <=1 1", level, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_frame(4'b0111);
        send_frame(4'b1001);
        in_valid = 1'b1;
        in_data  = 1'b1;
        repeat (2) tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || level !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got v%b l%0d want 0 0", out_valid, level);
        end
        rst = 1'b0;
        tick();
        send_frame(4'b1000);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'b1000 || level !== LW'(1)) begin
            errors++;
            $display("FAIL rstmid_fresh: got v%b d%b l%0d want 1 1000 1", out_valid, out_data, level);
        end
        drain();
    endtask

`ifdef HM_DESER_PARITY_EN
    task automatic test_parity();
        lane_word_t bits;
        bits = 4'b0011;
        out_ready = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            in_valid = 1'b1;
            in_data  = bits[i];
            tick();
        end
        in_data = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (par_err !== 1'b1 || out_data !== 4'b0011 || level !== LW'(1)) begin
            errors++;
            $display("FAIL parity_bad: got p%b d%b l%0d want 1 0011 1", par_err, out_data, level);
        end
        out_ready = 1'b1;
        send_frame(4'b0101);
        send_frame(4'b1110);
        repeat (2) tick();
        out_ready = 1'b0;
        checks++;
        if (par_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_sticky: got %b want 1", par_err);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (par_err !== 1'b0) begin
            errors++;
            $display("FAIL parity_clear: got %b want 0", par_err);
        end
        tick();
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 2) == 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3 * DEPTH) tick();
        out_ready = 1'b0;
        checks++;
        if (sb_q.size() != 0 || level !== '0) begin
            errors++;
            $display("FAIL random_drain: got queue %0d level %0d want 0 0", sb_q.size(), level);
        end
        $display("random done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_stall();
        test_stream();
        test_reset_mid();
`ifdef HM_DESER_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
